// File: rtl/vga_timing_gen_if.sv
// Raster coordinate and sync bundle produced by vga_timing_gen and consumed by
// sprite/overlay blocks.
interface vga_timing_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_start;
  logic       frame_start;

  modport master (
    output x, y, hsync, vsync, active, line_start, frame_start
  );

  modport slave (
    input x, y, hsync, vsync, active, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal and vertical phase FSMs with registered
// coordinates, syncs and decodes, all advancing only when ce is high.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  vga_timing_gen_if.master vid
);

  typedef enum logic [1:0] {HAct, HFp, HSync, HBp} h_state_e;
  typedef enum logic [1:0] {VAct, VFp, VSync, VBp} v_state_e;

  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, vsync_q, active_q, line_start_q, frame_start_q;

  // Last phase-counter value of each state.
  function automatic logic [9:0] h_last(h_state_e s);
    logic [9:0] l;
    l = '0;
    unique case (s)
      HAct:  l = 10'(H_ACTIVE - 1);
      HFp:   l = 10'(H_FP - 1);
      HSync: l = 10'(H_SYNC - 1);
      HBp:   l = 10'(H_BP - 1);
    endcase
    return l;
  endfunction

  function automatic logic [9:0] v_last(v_state_e s);
    logic [9:0] l;
    l = '0;
    unique case (s)
      VAct:  l = 10'(V_ACTIVE - 1);
      VFp:   l = 10'(V_FP - 1);
      VSync: l = 10'(V_SYNC - 1);
      VBp:   l = 10'(V_BP - 1);
    endcase
    return l;
  endfunction

  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_cnt_d   = h_cnt_q + 10'd1;
    v_cnt_d   = v_cnt_q;
    x_d       = x_q + 10'd1;
    y_d       = y_q;
    if (h_cnt_q == h_last(h_state_q)) begin
      h_cnt_d = '0;
      unique case (h_state_q)
        HAct:  h_state_d = HFp;
        HFp:   h_state_d = HSync;
        HSync: h_state_d = HBp;
        HBp: begin
          // Horizontal wrap: the only point where the vertical FSM moves.
          h_state_d = HAct;
          x_d       = '0;
          v_cnt_d   = v_cnt_q + 10'd1;
          y_d       = y_q + 10'd1;
          if (v_cnt_q == v_last(v_state_q)) begin
            v_cnt_d = '0;
            unique case (v_state_q)
              VAct:  v_state_d = VFp;
              VFp:   v_state_d = VSync;
              VSync: v_state_d = VBp;
              VBp: begin
                v_state_d = VAct;
                y_d       = '0;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_state_q     <= HAct;
      v_state_q     <= VAct;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (ce) begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      // Decodes use next-state values so they line up with x/y in the same cycle.
      hsync_q       <= (h_state_d == HSync) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= (v_state_d == VSync) ? SYNC_POL : ~SYNC_POL;
      active_q      <= (h_state_d == HAct) && (v_state_d == VAct);
      line_start_q  <= (x_d == 10'd0);
      frame_start_q <= (x_d == 10'd0) && (y_d == 10'd0);
    end
  end

  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.active      = active_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, and a scaled
// active-high-sync instance (36x17 total) for full-frame timing.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;
  int   tests = 0;
  int   fails = 0;

  vga_timing_gen_if vid_a ();
  vga_timing_gen_if vid_b ();

  vga_timing_gen u_dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .vid   (vid_a)
  );

  // Small timing: H 20/4/6/6 = 36, V 10/2/2/3 = 17, frame 612 cycles.
  vga_timing_gen #(
    .H_ACTIVE (20), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .vid   (vid_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ce    = 1'b1;
    repeat (3) step();
    tests++;
    if (vid_a.x !== 10'd0 || vid_a.y !== 10'd0) begin
      fails++; $display("FAIL rst_xy: x=%0d y=%0d want 0 0", vid_a.x, vid_a.y);
    end
    tests++;
    if ({vid_a.hsync, vid_a.vsync, vid_a.active, vid_a.line_start, vid_a.frame_start} !== 5'b11111)
    begin
      fails++;
      $display("FAIL rst_flags: hs=%b vs=%b act=%b ls=%b fs=%b want 11111", vid_a.hsync,
               vid_a.vsync, vid_a.active, vid_a.line_start, vid_a.frame_start);
    end
    tests++;
    if ({vid_b.hsync, vid_b.vsync} !== 2'b00) begin
      fails++; $display("FAIL rst_pol_hi: hs=%b vs=%b want 0 0", vid_b.hsync, vid_b.vsync);
    end
    reset = 1'b1;
    step();
    tests++;
    if (vid_a.x !== 10'd1 || vid_a.y !== 10'd0 || vid_b.x !== 10'd1) begin
      fails++;
      $display("FAIL rel_first: a.x=%0d a.y=%0d b.x=%0d want 1 0 1", vid_a.x, vid_a.y, vid_b.x);
    end
    tests++;
    if ({vid_a.line_start, vid_a.frame_start, vid_a.active} !== 3'b001) begin
      fails++;
      $display("FAIL rel_flags: ls=%b fs=%b act=%b want 0 0 1", vid_a.line_start,
               vid_a.frame_start, vid_a.active);
    end
  endtask

  task automatic test_horizontal();
    int n = 0;
    int xerr = 0, hs_err = 0, hs_cnt = 0, act_err = 0, act_cnt = 0, ls_cnt = 0;
    while (n < 1000 && vid_a.x !== 10'd0) begin step(); n++; end
    tests++;
    if (vid_a.x !== 10'd0 || vid_a.y !== 10'd1) begin
      fails++; $display("FAIL h_find_line: x=%0d y=%0d want 0 1", vid_a.x, vid_a.y);
    end
    for (int i = 0; i < 800; i++) begin
      if (vid_a.x !== 10'(i)) xerr++;
      if (vid_a.hsync !== ((i >= 656 && i <= 751) ? 1'b0 : 1'b1)) hs_err++;
      if (vid_a.hsync === 1'b0) hs_cnt++;
      if (vid_a.active !== ((i < 640) ? 1'b1 : 1'b0)) act_err++;
      if (vid_a.active === 1'b1) act_cnt++;
      if (vid_a.line_start === 1'b1) ls_cnt++;
      step();
    end
    tests++;
    if (xerr != 0) begin fails++; $display("FAIL h_x_seq: %0d bad x, want 0", xerr); end
    tests++;
    if (hs_cnt != 96) begin fails++; $display("FAIL h_hs_len: got %0d want 96", hs_cnt); end
    tests++;
    if (hs_err != 0) begin fails++; $display("FAIL h_hs_place: %0d bad, want 0", hs_err); end
    tests++;
    if (act_cnt != 640 || act_err != 0) begin
      fails++; $display("FAIL h_active: cnt=%0d err=%0d want 640 0", act_cnt, act_err);
    end
    tests++;
    if (ls_cnt != 1) begin fails++; $display("FAIL h_ls_cnt: got %0d want 1", ls_cnt); end
    tests++;
    if (vid_a.x !== 10'd0 || vid_a.y !== 10'd2 || vid_a.line_start !== 1'b1) begin
      fails++;
      $display("FAIL h_wrap: x=%0d y=%0d ls=%b want 0 2 1", vid_a.x, vid_a.y, vid_a.line_start);
    end
  endtask

  task automatic test_vertical();
    int n = 0;
    int pos_err = 0, hs_err = 0, vs_err = 0, act_cnt = 0, act_err = 0;
    int fs_cnt = 0, ls_cnt = 0, rise_at = -1, fall_at = -1;
    logic prev_vs;
    int ex, ey;
    while (n < 1000 && vid_b.frame_start !== 1'b1) begin step(); n++; end
    tests++;
    if (vid_b.x !== 10'd0 || vid_b.y !== 10'd0 || vid_b.frame_start !== 1'b1) begin
      fails++; $display("FAIL v_find_frame: x=%0d y=%0d want 0 0", vid_b.x, vid_b.y);
    end
    prev_vs = 1'b0;
    for (int i = 0; i < 612; i++) begin
      ex = i % 36;
      ey = i / 36;
      if (vid_b.x !== 10'(ex) || vid_b.y !== 10'(ey)) pos_err++;
      if (vid_b.hsync !== ((ex >= 24 && ex <= 29) ? 1'b1 : 1'b0)) hs_err++;
      if (vid_b.vsync !== ((ey == 12 || ey == 13) ? 1'b1 : 1'b0)) vs_err++;
      if (vid_b.active !== ((ex < 20 && ey < 10) ? 1'b1 : 1'b0)) act_err++;
      if (vid_b.active === 1'b1) act_cnt++;
      if (vid_b.frame_start === 1'b1) fs_cnt++;
      if (vid_b.line_start === 1'b1) ls_cnt++;
      if (!prev_vs && vid_b.vsync === 1'b1 && rise_at < 0) rise_at = i;
      if (prev_vs && vid_b.vsync === 1'b0 && fall_at < 0) fall_at = i;
      prev_vs = vid_b.vsync;
      step();
    end
    tests++;
    if (pos_err != 0) begin fails++; $display("FAIL v_xy_seq: %0d bad, want 0", pos_err); end
    tests++;
    if (hs_err != 0 || vs_err != 0) begin
      fails++; $display("FAIL v_sync_place: hs_err=%0d vs_err=%0d want 0 0", hs_err, vs_err);
    end
    tests++;
    if (rise_at != 432 || fall_at != 504) begin
      fails++;
      $display("FAIL v_vs_edges: assert=%0d deassert=%0d want 432 504", rise_at, fall_at);
    end
    tests++;
    if (act_cnt != 200 || act_err != 0) begin
      fails++; $display("FAIL v_active: cnt=%0d err=%0d want 200 0", act_cnt, act_err);
    end
    tests++;
    if (fs_cnt != 1 || ls_cnt != 17) begin
      fails++; $display("FAIL v_pulses: fs=%0d ls=%0d want 1 17", fs_cnt, ls_cnt);
    end
    tests++;
    if (vid_b.frame_start !== 1'b1) begin
      fails++; $display("FAIL v_frame_period: fs=%b want 1", vid_b.frame_start);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    while (n < 700 && !(vid_b.x === 10'd35 && vid_b.y === 10'd9)) begin step(); n++; end
    tests++;
    if (vid_b.x !== 10'd35 || vid_b.y !== 10'd9) begin
      fails++; $display("FAIL w_find_last_vis: x=%0d y=%0d want 35 9", vid_b.x, vid_b.y);
    end
    step();
    tests++;
    if (vid_b.x !== 10'd0 || vid_b.y !== 10'd10 || vid_b.active !== 1'b0 ||
        vid_b.line_start !== 1'b1 || vid_b.frame_start !== 1'b0) begin
      fails++;
      $display("FAIL w_end_vis: x=%0d y=%0d act=%b ls=%b fs=%b want 0 10 0 1 0", vid_b.x,
               vid_b.y, vid_b.active, vid_b.line_start, vid_b.frame_start);
    end
    n = 0;
    while (n < 700 && !(vid_b.x === 10'd35 && vid_b.y === 10'd16)) begin step(); n++; end
    tests++;
    if (vid_b.x !== 10'd35 || vid_b.y !== 10'd16 || vid_b.active !== 1'b0) begin
      fails++; $display("FAIL w_find_last: x=%0d y=%0d want 35 16", vid_b.x, vid_b.y);
    end
    step();
    tests++;
    if (vid_b.x !== 10'd0 || vid_b.y !== 10'd0 || vid_b.frame_start !== 1'b1 ||
        vid_b.active !== 1'b1) begin
      fails++;
      $display("FAIL w_frame_wrap: x=%0d y=%0d fs=%b act=%b want 0 0 1 1", vid_b.x, vid_b.y,
               vid_b.frame_start, vid_b.active);
    end
  endtask

  task automatic test_freeze();
    int n = 0, diff = 0;
    logic [9:0] sx, sy, bx;
    logic [4:0] sf;
    while (n < 1000 && vid_a.x !== 10'd655) begin step(); n++; end
    tests++;
    if (vid_a.x !== 10'd655 || vid_a.hsync !== 1'b1) begin
      fails++; $display("FAIL f_find_655: x=%0d hs=%b want 655 1", vid_a.x, vid_a.hsync);
    end
    sx = vid_a.x; sy = vid_a.y; bx = vid_b.x;
    sf = {vid_a.hsync, vid_a.vsync, vid_a.active, vid_a.line_start, vid_a.frame_start};
    ce = 1'b0;
    repeat (50) begin
      step();
      if (vid_a.x !== sx || vid_a.y !== sy || vid_b.x !== bx ||
          {vid_a.hsync, vid_a.vsync, vid_a.active, vid_a.line_start, vid_a.frame_start} !== sf)
        diff++;
    end
    tests++;
    if (diff != 0) begin fails++; $display("FAIL f_frozen: %0d changed cycles, want 0", diff); end
    ce = 1'b1;
    step();
    tests++;
    if (vid_a.x !== 10'd656 || vid_a.hsync !== 1'b0) begin
      fails++; $display("FAIL f_hs_assert: x=%0d hs=%b want 656 0", vid_a.x, vid_a.hsync);
    end
  endtask

  task automatic test_ce_toggle();
    int c = 0, run = 1, run_err = 0, seq_err = 0, exp_x;
    int r1 = -1, r2 = -1, hold1 = -1, fs_run = 0;
    bit started = 1'b0;
    logic prev_fs;
    logic [9:0] last_x;
    bit phase = 1'b1;
    last_x  = vid_a.x;
    prev_fs = vid_b.frame_start;
    while (c < 3000 && !(r2 >= 0 && hold1 >= 0)) begin
      ce    = phase;
      phase = ~phase;
      step();
      c++;
      if (vid_a.x === last_x) run++;
      else begin
        exp_x = (last_x == 10'd799) ? 0 : int'(last_x) + 1;
        if (vid_a.x !== 10'(exp_x)) seq_err++;
        if (started && run != 2) run_err++;
        started = 1'b1;
        run     = 1;
        last_x  = vid_a.x;
      end
      if (vid_b.frame_start === 1'b1) fs_run++;
      if (!prev_fs && vid_b.frame_start === 1'b1) begin
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      if (prev_fs && vid_b.frame_start !== 1'b1) begin
        if (r1 >= 0 && hold1 < 0) hold1 = fs_run;
        fs_run = 0;
      end
      prev_fs = vid_b.frame_start;
    end
    ce = 1'b1;
    tests++;
    if (run_err != 0 || seq_err != 0) begin
      fails++; $display("FAIL ce_hold2: run_err=%0d seq_err=%0d want 0 0", run_err, seq_err);
    end
    tests++;
    if (r1 < 0 || r2 < 0 || (r2 - r1) != 1224) begin
      fails++; $display("FAIL ce_frame_clks: r1=%0d r2=%0d want spacing 1224", r1, r2);
    end
    tests++;
    if (hold1 != 2) begin fails++; $display("FAIL ce_fs_hold: got %0d want 2", hold1); end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    ce = 1'b1;
    while (n < 700 && !(vid_b.x === 10'd5 && vid_b.y === 10'd12)) begin step(); n++; end
    tests++;
    if (vid_b.x !== 10'd5 || vid_b.y !== 10'd12 || vid_b.vsync !== 1'b1) begin
      fails++;
      $display("FAIL m_find: x=%0d y=%0d vs=%b want 5 12 1", vid_b.x, vid_b.y, vid_b.vsync);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (vid_a.x !== 10'd0 || vid_a.y !== 10'd0 ||
        {vid_a.hsync, vid_a.vsync, vid_a.active, vid_a.line_start, vid_a.frame_start} !== 5'b11111)
    begin
      fails++;
      $display("FAIL m_async_a: x=%0d y=%0d flags=%b want 0 0 11111", vid_a.x, vid_a.y,
               {vid_a.hsync, vid_a.vsync, vid_a.active, vid_a.line_start, vid_a.frame_start});
    end
    tests++;
    if (vid_b.x !== 10'd0 || vid_b.y !== 10'd0 ||
        {vid_b.hsync, vid_b.vsync, vid_b.active, vid_b.frame_start} !== 4'b0011) begin
      fails++;
      $display("FAIL m_async_b: x=%0d y=%0d flags=%b want 0 0 0011", vid_b.x, vid_b.y,
               {vid_b.hsync, vid_b.vsync, vid_b.active, vid_b.frame_start});
    end
    step();
    step();
    tests++;
    if (vid_a.x !== 10'd0 || vid_b.x !== 10'd0) begin
      fails++; $display("FAIL m_held: a.x=%0d b.x=%0d want 0 0", vid_a.x, vid_b.x);
    end
    reset = 1'b1;
    step();
    tests++;
    if (vid_a.x !== 10'd1 || vid_b.x !== 10'd1 || vid_b.y !== 10'd0) begin
      fails++;
      $display("FAIL m_release: a.x=%0d b.x=%0d b.y=%0d want 1 1 0", vid_a.x, vid_b.x, vid_b.y);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_wrap();
    test_freeze();
    test_ce_toggle();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
